// File: rtl/mac_fp_add_column_elastic.sv
// SIZE-lane FP32 add/subtract column with valid/ready handshake, tag and last sideband.
// Optional perf counters are enabled with `define MAC_FP_ADD_COL_PERF_EN.
module mac_fp_add_column_elastic #(
  parameter int unsigned SIZE    = 16,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE*32-1:0]   in_a,
  input  logic [SIZE*32-1:0]   in_b,
  input  logic                 in_sub,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE*32-1:0]   out_sum,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_last,
  output logic                 tile_done
`ifdef MAC_FP_ADD_COL_PERF_EN
  ,
  output logic [31:0]          perf_beats,
  output logic [31:0]          perf_stall
`endif
);

  // Aligned-and-added intermediate between the two adder halves.
  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        sign;
    logic        zsign;
    logic [7:0]  exp;
    logic [27:0] mag;
  } pre_t;

  // Swap so |x|>=|y|, align y with guard/round/sticky, then add or subtract magnitudes.
  function automatic pre_t fp_align(input logic [31:0] a, input logic [31:0] b);
    pre_t        p;
    logic        a_nan, b_nan, a_inf, b_inf, swap, sticky;
    logic [31:0] x, y;
    logic [26:0] mx, my, sh;
    logic [7:0]  d;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    swap   = b[30:0] > a[30:0];
    x      = swap ? b : a;
    y      = swap ? a : b;
    mx     = (x[30:23] == 8'h00) ? 27'd0 : {1'b1, x[22:0], 3'b000};
    my     = (y[30:23] == 8'h00) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    d      = x[30:23] - y[30:23];
    sticky = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (i < int'(d)) sticky = sticky | my[i];
    end
    sh     = (d >= 8'd27) ? 27'd0 : (my >> d);
    sh[0]  = sh[0] | sticky;
    p.nan   = a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]));
    p.inf   = a_inf | b_inf;
    p.sign  = x[31];
    p.zsign = a[31] & b[31];
    p.exp   = x[30:23];
    p.mag   = (x[31] ^ y[31]) ? ({1'b0, mx} - {1'b0, sh}) : ({1'b0, mx} + {1'b0, sh});
    return p;
  endfunction

  // Normalise and round to nearest-even; subnormal results flush to signed zero.
  function automatic logic [31:0] fp_round(input pre_t p);
    logic [26:0] n;
    logic [24:0] m;
    int          e;
    int          lz;
    if (p.nan) return 32'h7FC0_0000;
    if (p.inf) return {p.sign, 8'hFF, 23'd0};
    if (p.mag == 28'd0) return {p.zsign, 31'd0};
    e  = int'(p.exp);
    lz = 0;
    if (p.mag[27]) begin
      n = {p.mag[27:2], p.mag[1] | p.mag[0]};
      e = e + 1;
    end else begin
      for (int i = 0; i < 27; i++) begin
        if (p.mag[i]) lz = 26 - i;
      end
      n = p.mag[26:0] << lz;
      e = e - lz;
    end
    if (e <= 0) return {p.sign, 31'd0};
    m = {1'b0, n[26:3]} + 25'(n[2] & (n[1] | n[0] | n[3]));
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {p.sign, 8'hFF, 23'd0};
    return {p.sign, 8'(e), m[22:0]};
  endfunction

  logic                 w_adv;
  logic [LATENCY-1:0]   r_v;
  logic [LATENCY-1:0]   r_last;
  logic [TAG_W-1:0]     r_tag [LATENCY];
  logic                 r_tile_done;

  // The whole pipe moves together unless the head beat is waiting on downstream.
  assign w_adv    = ~r_v[LATENCY-1] | out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v    <= '0;
      r_last <= '0;
      for (int s = 0; s < LATENCY; s++) r_tag[s] <= '0;
    end else if (w_adv) begin
      r_v      <= {r_v[LATENCY-2:0], in_valid};
      r_last   <= {r_last[LATENCY-2:0], in_last};
      r_tag[0] <= in_tag;
      for (int s = 1; s < LATENCY; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    logic [31:0] w_b_eff;
    pre_t        w_pre;
    logic [31:0] w_rnd;
    pre_t        r_pre;
    logic [31:0] r_res [LATENCY-1];

    assign w_b_eff = in_b[g*32 +: 32] ^ {in_sub, 31'd0};
    assign w_pre   = fp_align(in_a[g*32 +: 32], w_b_eff);
    assign w_rnd   = fp_round(r_pre);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pre <= '0;
        for (int s = 0; s < LATENCY - 1; s++) r_res[s] <= '0;
      end else if (w_adv) begin
        r_pre    <= w_pre;
        r_res[0] <= w_rnd;
        for (int s = 1; s < LATENCY - 1; s++) r_res[s] <= r_res[s-1];
      end
    end

    assign out_sum[g*32 +: 32] = r_res[LATENCY-2];
  end

  always_ff @(posedge clk) begin
    if (rst) r_tile_done <= 1'b0;
    else     r_tile_done <= r_v[LATENCY-1] & out_ready & r_last[LATENCY-1];
  end

  assign out_valid = r_v[LATENCY-1];
  assign out_tag   = r_tag[LATENCY-1];
  assign out_last  = r_last[LATENCY-1];
  assign tile_done = r_tile_done;

`ifdef MAC_FP_ADD_COL_PERF_EN
  logic [31:0] r_perf_beats;
  logic [31:0] r_perf_stall;

  // Saturating handshake and head-stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_beats <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_v[LATENCY-1] & out_ready & (r_perf_beats != 32'hFFFF_FFFF))
        r_perf_beats <= r_perf_beats + 32'd1;
      if (r_v[LATENCY-1] & ~out_ready & (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_beats = r_perf_beats;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_mac_fp_add_column_elastic.sv
// Bench for mac_fp_add_column_elastic: vector table, hand sequences, random traffic vs. integer model.
module tb_mac_fp_add_column_elastic;
  localparam int unsigned SIZE    = 16;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned W       = SIZE * 32;

  logic             clk, rst, in_valid, in_ready, in_sub, in_last;
  logic             out_valid, out_ready, out_last, tile_done;
  logic [W-1:0]     in_a, in_b, out_sum, drv_exp;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef MAC_FP_ADD_COL_PERF_EN
  logic [31:0]      perf_beats, perf_stall;
`endif

  mac_fp_add_column_elastic #(.SIZE(SIZE), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_tag(out_tag), .out_last(out_last), .tile_done(tile_done)
`ifdef MAC_FP_ADD_COL_PERF_EN
    , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic [W-1:0]     sum;
    logic [TAG_W-1:0] tag;
    logic             last;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] e;
  } vec_t;

  exp_t             exp_q[$];
  bit               mon_en = 1'b0;
  bit               exp_done = 1'b0;
  bit               prev_stall = 1'b0;
  logic [W-1:0]     prev_sum;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_last;
  int               n_out = 0;
  int               n_stall = 0;
  int               n_done = 0;

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else if (mon_en) begin
      chk(in_ready == (!out_valid || out_ready), "in_ready", W'(in_ready), W'(!out_valid || out_ready));
      chk(tile_done == exp_done, "tile_done", W'(tile_done), W'(exp_done));
      if (tile_done) n_done++;
      if (prev_stall) begin
        chk(out_valid == 1'b1, "hold_valid", W'(out_valid), W'(1));
        chk(out_sum == prev_sum, "hold_sum", out_sum, prev_sum);
        chk({out_tag, out_last} == {prev_tag, prev_last}, "hold_tag_last",
            W'({out_tag, out_last}), W'({prev_tag, prev_last}));
      end
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", W'(out_tag), W'(0));
        end else begin
          e = exp_q.pop_front();
          chk(out_sum == e.sum, "sum", out_sum, e.sum);
          chk({out_tag, out_last} == {e.tag, e.last}, "tag_last",
              W'({out_tag, out_last}), W'({e.tag, e.last}));
          exp_done = e.last;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(exp_t'{drv_exp, in_tag, in_last});
      prev_stall = out_valid && !out_ready;
      if (prev_stall) n_stall++;
      prev_sum  = out_sum;
      prev_tag  = out_tag;
      prev_last = out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Exact FP32 encoding of an integer with magnitude below 2^24.
  function automatic logic [31:0] int_to_fp(input int v);
    int   m;
    int   p;
    logic s;
    if (v == 0) return 32'd0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (m >= (1 << i)) p = i;
    return {s, 8'(127 + p), 23'((m << (23 - p)) & 32'h007F_FFFF)};
  endfunction

  task automatic make_rand(output logic [W-1:0] a, output logic [W-1:0] b,
                           output logic [W-1:0] e, output logic sub);
    int x, y, r;
    sub = 1'($urandom_range(0, 1));
    for (int l = 0; l < SIZE; l++) begin
      x = int'($urandom_range(0, 2097152)) - 1048576;
      y = int'($urandom_range(0, 2097152)) - 1048576;
      if ($urandom_range(0, 7) == 0) y = sub ? x : -x;
      r = sub ? x - y : x + y;
      a[l*32 +: 32] = int_to_fp(x);
      b[l*32 +: 32] = int_to_fp(y);
      e[l*32 +: 32] = int_to_fp(r);
    end
  endtask

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                           input logic [TAG_W-1:0] tag, input logic last,
                           input logic [W-1:0] e, output int waits);
    bit acc;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_last = last; drv_exp = e;
    in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      step();
      waits++;
      if (acc) break;
      if (waits > 200) begin
        chk(1'b0, "send_timeout", W'(waits), W'(200));
        break;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk(n < 500, "drain_timeout", W'(n), W'(500));
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  vec_t          tbl [14];
  logic [W-1:0]  ra, rb, re;
  logic          rsub;
  int            w, total, n, n0, s0, d0;
  bit            feed_done;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    tbl[1]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000};
    tbl[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
    tbl[3]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
    tbl[4]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    tbl[5]  = '{32'h3DCCCCCD, 32'h3E4CCCCD, 1'b0, 32'h3E99999A};
    tbl[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
    tbl[7]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001};
    tbl[8]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
    tbl[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000};
    tbl[10] = '{32'hBF800000, 32'hC0000000, 1'b0, 32'hC0400000};
    tbl[11] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000};
    tbl[12] = '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000};
    tbl[13] = '{32'hC0400000, 32'hC0400000, 1'b1, 32'h00000000};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_tag = '0; in_last = 1'b0; out_ready = 1'b1; drv_exp = '0;
    repeat (3) step();
    rst = 1'b0;
    chk(out_valid == 1'b0, "rst_out_valid", W'(out_valid), W'(0));
    chk(out_sum == '0, "rst_out_sum", out_sum, W'(0));
    chk({out_tag, out_last, tile_done} == '0, "rst_tag_last_done",
        W'({out_tag, out_last, tile_done}), W'(0));
    chk(in_ready == 1'b1, "rst_in_ready", W'(in_ready), W'(1));
    mon_en = 1'b1;

    // Basic add with exact latency.
    send_beat({SIZE{32'h3F800000}}, {SIZE{32'h40000000}}, 1'b0, 4'd5, 1'b0,
              {SIZE{32'h40400000}}, w);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk(n == LATENCY, "latency", W'(n), W'(LATENCY));
    chk(out_sum == {SIZE{32'h40400000}}, "basic_sum", out_sum, {SIZE{32'h40400000}});
    chk(out_tag == 4'd5, "basic_tag", W'(out_tag), W'(5));
    drain();

    // Subtract, lane 3 cancels to +0.
    for (int l = 0; l < SIZE; l++) begin
      ra[l*32 +: 32] = (l == 3) ? 32'h3F800000 : 32'h40000000;
      rb[l*32 +: 32] = 32'h3F800000;
      re[l*32 +: 32] = (l == 3) ? 32'h00000000 : 32'h3F800000;
    end
    send_beat(ra, rb, 1'b1, 4'd1, 1'b0, re, w);
    in_valid = 1'b0;
    drain();

    // Vector table streamed back-to-back.
    total = 0;
    for (int i = 0; i < 14; i++) begin
      send_beat({SIZE{tbl[i].a}}, {SIZE{tbl[i].b}}, tbl[i].sub, TAG_W'(i), 1'b0,
                {SIZE{tbl[i].e}}, w);
      total += w;
    end
    in_valid = 1'b0;
    chk(total == 14, "throughput", W'(total), W'(14));
    drain();

    // Backpressure: head stalled for 4 cycles after first output.
    reset_dut();
    n0 = n_out; s0 = n_stall;
    fork
      begin
        for (int t = 0; t < 6; t++) begin
          make_rand(ra, rb, re, rsub);
          send_beat(ra, rb, rsub, TAG_W'(t), 1'b0, re, w);
        end
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          step();
          n++;
        end
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
      end
    join
    drain();
    chk(n_out - n0 == 6, "bp_beats", W'(n_out - n0), W'(6));
    chk(n_stall - s0 == 4, "bp_stall_cycles", W'(n_stall - s0), W'(4));
`ifdef MAC_FP_ADD_COL_PERF_EN
    chk(perf_beats == 32'd6, "perf_beats", W'(perf_beats), W'(6));
    chk(perf_stall == 32'd4, "perf_stall", W'(perf_stall), W'(4));
`endif

    // Four-beat tile, last on the final beat.
    d0 = n_done;
    for (int t = 0; t < 4; t++) begin
      make_rand(ra, rb, re, rsub);
      send_beat(ra, rb, rsub, TAG_W'(8 + t), (t == 3), re, w);
    end
    in_valid = 1'b0;
    drain();
    repeat (3) step();
    chk(n_done - d0 == 1, "tile_done_count", W'(n_done - d0), W'(1));

    // Reset with three beats in flight.
    for (int t = 0; t < 3; t++) begin
      make_rand(ra, rb, re, rsub);
      send_beat(ra, rb, rsub, TAG_W'(12 + t), 1'b1, re, w);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk(out_valid == 1'b0, "mid_rst_out_valid", W'(out_valid), W'(0));
    chk(out_tag == '0, "mid_rst_out_tag", W'(out_tag), W'(0));
    chk(in_ready == 1'b1, "mid_rst_in_ready", W'(in_ready), W'(1));
    chk(out_sum == '0, "mid_rst_out_sum", out_sum, W'(0));
    out_ready = 1'b1;
    n0 = n_out;
    repeat (10) step();
    chk(n_out == n0, "no_stale_beat", W'(n_out), W'(n0));

    // Random traffic with random gaps and backpressure.
    n0 = n_out;
    feed_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
          end
          make_rand(ra, rb, re, rsub);
          send_beat(ra, rb, rsub, TAG_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), re, w);
        end
        in_valid = 1'b0;
        feed_done = 1'b1;
      end
      begin
        while (!feed_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk(n_out - n0 == 300, "random_beats", W'(n_out - n0), W'(300));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_fp_add_column_elastic.md
Name: mac_fp_add_column_elastic

Overview:
- SIZE-lane single-precision FP add/subtract column for the MAC accelerator.
- Successor of the global-stall add column:
  - valid/ready elastic handshake instead of an external stall;
  - per-beat add/subtract op;
  - generic TAG_W-bit sideband plus last flag in place of fixed b_col/done pipes.
- Sits between the multiplier array and the result writeback/accumulate buffer.

Parameters:
- SIZE, 16, number of 32-bit lanes.
- LATENCY, 3, pipeline depth. Must equal float_adder latency; legal values are ≥2.
- TAG_W, 4, sideband tag width (e.g. B-column index).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_a  in  SIZE*32  operand A, lane i at [i*32+:32]
- in_b  in  SIZE*32  operand B, same lane layout
- in_sub  in  1  per-beat op: 0 = A+B, 1 = A−B
- in_tag  in  TAG_W  sideband carried with the beat
- in_last  in  1  marks final beat of a tile
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_sum  out  SIZE*32  per-lane results
- out_tag  out  TAG_W  tag of the result beat
- out_last  out  1  last flag of the result beat
- tile_done  out  1  one-cycle pulse when a beat with last=1 is accepted downstream

Behaviour:
- Advance enable: adv = ~v[LATENCY-1] | out_ready.
  - All stages (adder lanes, valid, tag, last) shift only when adv=1.
  - float_adder instances get stall = ~adv and rst_n = ~rst.
- in_ready = adv, purely combinational. No combinational path from in_valid to in_ready.
- Valid pipe v[0..LATENCY-1]:
  - v[0] <= in_valid & adv.
  - Bubbles propagate as v=0.
  - out_valid = v[LATENCY-1].
- Subtract: lane operand B gets sign bit 31 XORed with in_sub before entering the adder. Flipping applies to NaN/zero too: 0 − 0 yields +0 per float_adder rules.
- Tag/last pipes:
  - TAG_W×LATENCY and 1×LATENCY shift registers, enabled by adv.
  - Beats stay aligned with their sums.
  - Output holds stable while out_valid & ~out_ready.
- Latency: an accepted beat appears on out_* exactly LATENCY cycles later if out_ready stays high. Throughput is 1 beat/cycle.
- Backpressure: when out_valid=1 and out_ready=0, the whole pipe freezes and in_ready=0. There is no bubble collapse; a full pipe with a stalled head stalls upstream.
- Empty pipe (all v=0): in_ready=1 regardless of out_ready.
- tile_done = out_valid & out_ready & out_last, registered. It pulses one cycle after the handshake.
- Reset:
  - Synchronous. Clears the v, tag and last pipes; out_valid=0, out_tag=0, out_last=0, tile_done=0, out_sum=0 (adder output registers cleared).
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats. No partial beat is emitted.
- Simultaneous in and out handshake in the same cycle is legal and sustains full throughput.

Optional Feature:
- Macro: MAC_FP_ADD_COL_PERF_EN.
- Defined:
  - Adds outputs perf_beats [31:0] and perf_stall [31:0].
  - perf_beats increments on each output handshake.
  - perf_stall increments each cycle with out_valid & ~out_ready.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: these ports and counters do not exist. Functional behaviour is identical in both builds.

Test Plan:
- Basic add:
  - Stimulus: all lanes a=0x3F800000 (1.0), b=0x40000000 (2.0), sub=0, tag=5, out_ready=1.
  - Response: out_sum lanes=0x40400000 (3.0) and out_tag=5 exactly 3 cycles after acceptance.
- Subtract:
  - Stimulus: a=0x40000000, b=0x3F800000, sub=1.
  - Response: lanes=0x3F800000. Lane 3 with a=b=0x3F800000 gives 0x00000000.
- Backpressure:
  - Stimulus: stream 6 beats with tags 0..5, drop out_ready for 4 cycles after the first output.
  - Response: in_ready low while stalled, out_* held stable, no beat lost or duplicated, tags emerge 0..5 in order.
- Last/done:
  - Stimulus: 4-beat tile with last on beat 3.
  - Response: out_last=1 only on the 4th output; tile_done pulses once, one cycle after that handshake.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 3 beats in flight.
  - Response: next cycle out_valid=0, out_tag=0, in_ready=1; no stale beat emerges afterwards.
- Perf counters (MAC_FP_ADD_COL_PERF_EN defined):
  - Stimulus: run the backpressure scenario.
  - Response: perf_beats=6, perf_stall=4.
